// File: rtl/rv32i_axil_master_if.sv
// AXI4-Lite bus bundle between the core bridge (master) and a memory-mapped slave.
interface rv32i_axil_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid, awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid, wready;
  logic [1:0]              bresp;
  logic                    bvalid, bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid, arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid, rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/rv32i_axil_master.sv
// Single-outstanding core memory port to AXI4-Lite master bridge.
// Optional watchdog on hung transactions: define AXI_TIMEOUT_EN.
module rv32i_axil_master #(
  parameter int         ADDR_WIDTH     = 32,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [2:0] AXI_PROT       = 3'b000,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_req,
  input  logic                    mem_we,
  output logic                    mem_ready,
  output logic                    mem_valid,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_err,
  rv32i_axil_master_if.master     m_axi
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_READ, S_RRESP,
`ifdef AXI_TIMEOUT_EN
    S_DONE, S_DRAIN
`else
    S_DONE
`endif
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata, r_rdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic r_aw_done, r_w_done, r_mem_valid, r_mem_err;

  logic w_accept, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_aw_fin, w_w_fin;
  assign w_accept = (r_state == S_IDLE) && mem_req;
  assign w_aw_hs  = r_awvalid && m_axi.awready;
  assign w_w_hs   = r_wvalid  && m_axi.wready;
  assign w_b_hs   = r_bready  && m_axi.bvalid;
  assign w_ar_hs  = r_arvalid && m_axi.arready;
  assign w_r_hs   = r_rready  && m_axi.rvalid;
  assign w_aw_fin = r_aw_done || w_aw_hs;
  assign w_w_fin  = r_w_done  || w_w_hs;

`ifdef AXI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic          w_busy, w_fin;
  assign w_busy = (r_state == S_WRITE) || (r_state == S_WRESP) ||
                  (r_state == S_READ)  || (r_state == S_RRESP);
  // Any handshake that moves the transaction forward a state cancels the timeout.
  assign w_fin  = ((r_state == S_WRITE) && w_aw_fin && w_w_fin) ||
                  ((r_state == S_READ)  && w_ar_hs) || w_b_hs || w_r_hs;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_err   <= 1'b0;
`ifdef AXI_TIMEOUT_EN
      r_cnt       <= '0;
      r_we        <= 1'b0;
`endif
    end else begin
      r_mem_valid <= 1'b0;
      r_mem_err   <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_addr    <= mem_addr;
          r_wdata   <= mem_wdata;
          r_wstrb   <= mem_wstrb;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
`ifdef AXI_TIMEOUT_EN
          r_we      <= mem_we;
          r_cnt     <= '0;
`endif
          if (mem_we) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= S_WRITE;
          end else begin
            r_arvalid <= 1'b1;
            r_state   <= S_READ;
          end
        end
        S_WRITE: begin
          if (w_aw_hs) begin r_awvalid <= 1'b0; r_aw_done <= 1'b1; end
          if (w_w_hs)  begin r_wvalid  <= 1'b0; r_w_done  <= 1'b1; end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= S_WRESP;
          end
        end
        S_WRESP: if (w_b_hs) begin
          r_bready    <= 1'b0;
          r_mem_valid <= 1'b1;
          r_mem_err   <= |m_axi.bresp;
          r_state     <= S_DONE;
        end
        S_READ: if (w_ar_hs) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= S_RRESP;
        end
        S_RRESP: if (w_r_hs) begin
          r_rready    <= 1'b0;
          r_rdata     <= m_axi.rdata;
          r_mem_valid <= 1'b1;
          r_mem_err   <= |m_axi.rresp;
          r_state     <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
`ifdef AXI_TIMEOUT_EN
        S_DRAIN: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_ar_hs) r_arvalid <= 1'b0;
          if (w_b_hs || w_r_hs) begin
            r_bready <= 1'b0;
            r_rready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
`ifdef AXI_TIMEOUT_EN
      // Overrides the case above: error completion now, swallow the late response in DRAIN.
      if (w_busy) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(TIMEOUT_CYCLES - 1) && !w_fin) begin
          r_mem_valid <= 1'b1;
          r_mem_err   <= 1'b1;
          r_rdata     <= DATA_WIDTH'(32'hDEAD_BEEF);
          r_bready    <= r_we;
          r_rready    <= !r_we;
          r_state     <= S_DRAIN;
        end
      end
`endif
    end
  end

  assign mem_ready     = w_accept;
  assign mem_valid     = r_mem_valid;
  assign mem_err       = r_mem_err;
  assign mem_rdata     = r_rdata;
  assign m_axi.awaddr  = r_addr;
  assign m_axi.awprot  = AXI_PROT;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arprot  = AXI_PROT;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;

endmodule

// File: tb/tb_rv32i_axil_master.sv
// Bench for rv32i_axil_master: random core + configurable-delay slave, checked every
// cycle against a transaction-level model, plus directed literal cases.
module tb_rv32i_axil_master;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef AXI_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic        mem_ready, mem_valid, mem_err;

  rv32i_axil_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi();

  rv32i_axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_PROT(3'b000),
                      .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .m_axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr, wdata; logic [3:0] wstrb; } req_t;
  typedef struct { int aw_dly, w_dly, ar_dly, rsp_dly; logic [1:0] resp; logic [31:0] rdata; } rsp_t;

  int n_tot = 0, n_pass = 0, cyc = 0;
  req_t dq[$];
  rsp_t dr[$];
  req_t hreq, cur;
  rsp_t cur_s;
  bit   holding, auto_req, mdl_on, tmo_disc;
  // Transaction-level model state
  bit   busy, s_act, hs_prev, hs_prev_rd;
  logic hs_prev_err;
  logic [31:0] hs_prev_rdata, mdl_rdata;
  int   aw_cnt, w_cnt, ar_cnt, tcyc, resp_age;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  int   acc_cyc, mv_cyc, mv_cnt;
  logic last_err;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic mdl_clear(logic [31:0] rd);
    busy = 0; s_act = 0; hs_prev = 0; holding = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; tcyc = 0; resp_age = 0;
    mdl_rdata = rd;
    cur = '{1'b0, 32'h0, 32'h0, 4'h0};
    cur_s = '{0, 0, 0, 0, 2'b00, 32'h0};
  endtask

  task automatic slave_idle();
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = 0;
  endtask

  task automatic cycle();
    bit ph, hs_now, hs_rd;
    logic hs_err;
    logic [31:0] hs_rdata;
    @(negedge clk);
    // core side
    if (mem_valid) mem_req = 1'b0;
    else begin
      if (!holding) begin
        if (dq.size() > 0) begin hreq = dq.pop_front(); holding = 1; end
        else if (auto_req && $urandom_range(0, 99) < 40) begin
          hreq.we    = 1'($urandom_range(0, 1));
          hreq.addr  = $urandom() & 32'hFFFF_FFFC;
          hreq.wdata = $urandom();
          hreq.wstrb = 4'($urandom_range(0, 15));
          holding = 1;
        end
      end
      mem_req = holding;
    end
    if (holding) begin
      mem_we = hreq.we; mem_addr = hreq.addr; mem_wdata = hreq.wdata; mem_wstrb = hreq.wstrb;
    end else begin
      mem_we = 1'($urandom_range(0, 1)); mem_addr = $urandom(); mem_wdata = $urandom();
      mem_wstrb = 4'($urandom());
    end
    // slave side
    ph = s_act && (cur.we ? (aw_cnt > 0 && w_cnt > 0) : (ar_cnt > 0));
    axi.awready = s_act && cur.we && tcyc >= cur_s.aw_dly;
    axi.wready  = s_act && cur.we && tcyc >= cur_s.w_dly;
    axi.arready = s_act && !cur.we && tcyc >= cur_s.ar_dly;
    axi.bvalid  = ph && cur.we && resp_age >= cur_s.rsp_dly;
    axi.bresp   = cur_s.resp;
    axi.rvalid  = ph && !cur.we && resp_age >= cur_s.rsp_dly;
    axi.rresp   = cur_s.resp;
    axi.rdata   = axi.rvalid ? cur_s.rdata : $urandom();
    #1;
    if (hs_prev && hs_prev_rd) mdl_rdata = hs_prev_rdata;
    if (mdl_on) begin
      chk("mem_ready", mem_ready, mem_req && !busy && !s_act);
      chk("mem_valid", mem_valid, hs_prev);
      if (hs_prev) chk("mem_err", mem_err, hs_prev_err);
      chk("mem_rdata", mem_rdata, mdl_rdata);
      chk("awvalid", axi.awvalid, s_act && cur.we && aw_cnt == 0);
      chk("wvalid",  axi.wvalid,  s_act && cur.we && w_cnt == 0);
      chk("arvalid", axi.arvalid, s_act && !cur.we && ar_cnt == 0);
      chk("bready",  axi.bready,  s_act && cur.we && aw_cnt > 0 && w_cnt > 0);
      chk("rready",  axi.rready,  s_act && !cur.we && ar_cnt > 0);
      if (axi.awvalid) begin chk("awaddr", axi.awaddr, cur.addr); chk("awprot", axi.awprot, 0); end
      if (axi.wvalid)  begin chk("wdata", axi.wdata, cur.wdata); chk("wstrb", axi.wstrb, cur.wstrb); end
      if (axi.arvalid) begin chk("araddr", axi.araddr, cur.addr); chk("arprot", axi.arprot, 0); end
    end
    // bookkeeping
    hs_now = 0; hs_rd = 0; hs_err = 0; hs_rdata = 0;
    if (axi.awvalid && axi.awready) begin aw_cnt++; cap_awaddr = axi.awaddr; end
    if (axi.wvalid && axi.wready) begin w_cnt++; cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; end
    if (axi.arvalid && axi.arready) begin ar_cnt++; cap_araddr = axi.araddr; end
    if (s_act && cur.we && axi.bvalid && axi.bready) begin
      s_act = 0; hs_now = 1; hs_err = |axi.bresp;
    end
    if (s_act && !cur.we && axi.rvalid && axi.rready) begin
      s_act = 0; hs_now = 1; hs_err = |axi.rresp; hs_rd = 1; hs_rdata = axi.rdata;
    end
    if (ph) resp_age++;
    if (s_act) tcyc++;
    if (mem_valid) begin busy = 0; mv_cyc = cyc; mv_cnt++; last_err = mem_err; end
    if (mem_req && mem_ready) begin
      cur = hreq; holding = 0; busy = 1; s_act = 1;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; tcyc = 0; resp_age = 0; acc_cyc = cyc;
      if (dr.size() > 0) cur_s = dr.pop_front();
      else begin
        cur_s.aw_dly = $urandom_range(0, 2); cur_s.w_dly = $urandom_range(0, 2);
        cur_s.ar_dly = $urandom_range(0, 2); cur_s.rsp_dly = $urandom_range(0, 2);
        cur_s.resp   = ($urandom_range(0, 99) < 20) ? 2'($urandom_range(1, 3)) : 2'b00;
        cur_s.rdata  = $urandom();
      end
    end
    hs_prev = hs_now && !tmo_disc; hs_prev_rd = hs_rd; hs_prev_err = hs_err; hs_prev_rdata = hs_rdata;
    cyc++;
  endtask

  task automatic run_until_mv(string nm, int lim);
    int start = mv_cnt;
    for (int i = 0; i < lim && mv_cnt == start; i++) cycle();
    chk({nm, "_completed"}, mv_cnt - start, 1);
  endtask

  task automatic chk_idle_outputs(string nm);
    chk({nm, "_mem_valid"}, mem_valid, 0); chk({nm, "_mem_ready"}, mem_ready, 0);
    chk({nm, "_mem_err"}, mem_err, 0);     chk({nm, "_mem_rdata"}, mem_rdata, 0);
    chk({nm, "_awvalid"}, axi.awvalid, 0); chk({nm, "_wvalid"}, axi.wvalid, 0);
    chk({nm, "_bready"}, axi.bready, 0);   chk({nm, "_arvalid"}, axi.arvalid, 0);
    chk({nm, "_rready"}, axi.rready, 0);   chk({nm, "_awaddr"}, axi.awaddr, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; mem_req = 0; slave_idle();
    @(negedge clk);
    chk_idle_outputs("rst");
    rst_n = 1;
    mdl_clear(32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_mv;
    slave_idle();
    mdl_clear(32'h0);
    auto_req = 0; mdl_on = 1; tmo_disc = 0; mv_cnt = 0;
    @(negedge clk); @(negedge clk);
    chk_idle_outputs("init");
    rst_n = 1;

    // zero-wait write
    dr.push_back('{0, 0, 0, 0, 2'b00, 32'h0});
    dq.push_back('{1'b1, 32'h100, 32'hA5A5_0001, 4'hF});
    run_until_mv("wr0", 20);
    chk("wr0_awaddr", cap_awaddr, 32'h100);
    chk("wr0_wdata", cap_wdata, 32'hA5A5_0001);
    chk("wr0_wstrb", cap_wstrb, 4'hF);
    chk("wr0_latency", mv_cyc - acc_cyc, 3);
    chk("wr0_err", last_err, 0);

    // zero-wait read
    dr.push_back('{0, 0, 0, 0, 2'b00, 32'h1234_5678});
    dq.push_back('{1'b0, 32'h200, 32'h0, 4'h0});
    run_until_mv("rd0", 20);
    chk("rd0_araddr", cap_araddr, 32'h200);
    chk("rd0_rdata", mem_rdata, 32'h1234_5678);
    chk("rd0_latency", mv_cyc - acc_cyc, 3);

    // skewed writes: W first, AW first, same cycle
    dr.push_back('{3, 0, 0, 0, 2'b00, 32'h0});
    dq.push_back('{1'b1, 32'h104, 32'h1111_2222, 4'h3});
    run_until_mv("skw_w", 30);
    chk("skw_w_latency", mv_cyc - acc_cyc, 6);
    dr.push_back('{0, 3, 0, 0, 2'b00, 32'h0});
    dq.push_back('{1'b1, 32'h108, 32'h3333_4444, 4'hC});
    run_until_mv("skw_aw", 30);
    chk("skw_aw_latency", mv_cyc - acc_cyc, 6);
    dr.push_back('{2, 2, 0, 0, 2'b00, 32'h0});
    dq.push_back('{1'b1, 32'h10C, 32'h5555_6666, 4'h5});
    run_until_mv("skw_eq", 30);
    chk("skw_eq_latency", mv_cyc - acc_cyc, 5);
    chk("skw_rdata_kept", mem_rdata, 32'h1234_5678);

    // error responses
    dr.push_back('{0, 0, 0, 0, 2'b10, 32'h0});
    dq.push_back('{1'b1, 32'h110, 32'h0BAD_0BAD, 4'hF});
    run_until_mv("berr", 20);
    chk("berr_err", last_err, 1);
    dr.push_back('{0, 0, 0, 0, 2'b11, 32'hCAFE_F00D});
    dq.push_back('{1'b0, 32'h114, 32'h0, 4'h0});
    run_until_mv("rerr", 20);
    chk("rerr_err", last_err, 1);
    chk("rerr_rdata", mem_rdata, 32'hCAFE_F00D);

    // request held while busy is taken only once the block is idle again
    dr.push_back('{0, 0, 0, 3, 2'b00, 32'hABCD_0001});
    dr.push_back('{0, 0, 0, 0, 2'b00, 32'h0});
    dq.push_back('{1'b0, 32'h120, 32'h0, 4'h0});
    dq.push_back('{1'b1, 32'h124, 32'h7777_8888, 4'hF});
    run_until_mv("hold1", 20);
    first_mv = mv_cyc;
    run_until_mv("hold2", 20);
    chk("hold2_accept", acc_cyc, first_mv + 1);
    chk("hold2_awaddr", cap_awaddr, 32'h124);

    // reset in the middle of a read response wait
    dr.push_back('{0, 0, 0, 6, 2'b00, 32'h1111_1111});
    dq.push_back('{1'b0, 32'h300, 32'h0, 4'h0});
    for (int i = 0; i < 10 && !axi.rready; i++) cycle();
    chk("rst_mid_rready_seen", axi.rready, 1);
    do_reset();
    for (int i = 0; i < 8; i++) cycle();

    // randomized traffic
    auto_req = 1;
    for (int i = 0; i < 600; i++) cycle();
    auto_req = 0;
    for (int i = 0; i < 60 && (busy || holding); i++) cycle();
    chk("drain_idle", busy || holding, 0);

`ifdef AXI_TIMEOUT_EN
    mdl_on = 0; tmo_disc = 1;
    dr.push_back('{0, 0, 0, 15, 2'b00, 32'h5555_5555});
    dq.push_back('{1'b0, 32'h400, 32'h0, 4'h0});
    for (int i = 0; i < 30 && !mem_valid; i++) cycle();
    chk("tmo_valid", mem_valid, 1);
    chk("tmo_err", mem_err, 1);
    chk("tmo_rdata", mem_rdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 30 && s_act; i++) begin
      cycle();
      chk("tmo_drain_no_valid", mem_valid, 0);
    end
    chk("tmo_resp_taken", s_act, 0);
    tmo_disc = 0; hs_prev = 0; mdl_rdata = 32'hDEAD_BEEF; mdl_on = 1;
    dr.push_back('{0, 0, 0, 0, 2'b00, 32'h7777_0001});
    dq.push_back('{1'b0, 32'h404, 32'h0, 4'h0});
    run_until_mv("tmo_next", 20);
    chk("tmo_next_rdata", mem_rdata, 32'h7777_0001);
    chk("tmo_next_err", last_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
